emb_seq_ctrl: RTL and testbench

//  Time-multiplexed sequencer for a single shared emb_block. Accepts one N-char word, issues
//  one run per character to the block, gathers each EMB_DIM*N_LEN result into a packed output

---
 rtl/emb_seq_ctrl_pkg.sv | 31 +++
 rtl/emb_seq_ctrl_if.sv | 34 +++
 rtl/emb_seq_ctrl.sv | 118 +++++++++++
 tb/tb_emb_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emb_seq_ctrl_pkg.sv
// Shared sizes, state encoding and bus types for the embedding sequencer.
// Latency: n/a (compile-time constants and a pure helper function only).
// Backpressure: n/a.
package emb_seq_ctrl_pkg;

    localparam int N        = 10;
    localparam int CHAR_LEN = 8;
    localparam int EMB_DIM  = 24;
    localparam int N_LEN    = 16;

    // One character's embedding result, and the index width for N characters
    localparam int SLICE_W = EMB_DIM * N_LEN;
    localparam int IDX_W   = $clog2(N);

    // Controller state encoding, kept numerically identical to the embedding layer's
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic [CHAR_LEN-1:0]  char_t;
    typedef logic [N*CHAR_LEN-1:0] word_t;
    typedef logic [SLICE_W-1:0]   emb_t;
    typedef logic [N*SLICE_W-1:0] qword_t;

    // Character i of a packed word (char 0 in the least significant bits)
    function automatic char_t char_at(input word_t w, input int i);
        return w[i*CHAR_LEN +: CHAR_LEN];
    endfunction

endpackage

// File: rtl/emb_seq_ctrl_if.sv
// Word handshake plus shared emb_block connection for the sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the word input, out_valid/out_ready on the result.
interface emb_seq_ctrl_if;
    import emb_seq_ctrl_pkg::*;

    // Word-side handshake
    logic   in_valid;
    logic   in_ready;
    word_t  d;
    logic   out_valid;
    logic   out_ready;
    qword_t q;
    logic   err;

    // Shared emb_block side
    logic   blk_run;
    char_t  blk_d;
    logic   blk_valid;
    emb_t   blk_q;

    // Sequencer view
    modport slave (
        input  in_valid, d, out_ready, blk_valid, blk_q,
        output in_ready, out_valid, q, err, blk_run, blk_d
    );

    // Environment view: word producer/consumer and the emb_block itself
    modport master (
        output in_valid, d, out_ready, blk_valid, blk_q,
        input  in_ready, out_valid, q, err, blk_run, blk_d
    );

endinterface

// File: rtl/emb_seq_ctrl.sv
// Runs one shared emb_block once per character of an N-char word and packs the results.
// Latency: accept at cycle a -> out_valid at a+1+sum(per-char cost); k+1 cycles per char.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module emb_seq_ctrl
    import emb_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    emb_seq_ctrl_if.slave bus
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]       state;
    word_t            d_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [TW-1:0]    tcnt;
    logic             armed;

    logic             out_valid_r;
    logic             blk_run_r;
    char_t            blk_d_r;
    qword_t           q_r;
    logic             err_r;

    logic             last_char;
    logic             cap;
    logic             tmo;

    assign last_char = (idx == IDX_W'(N - 1));
    assign idx_nxt   = idx + IDX_W'(1);

    // A result only counts once valid has been seen low after the run pulse,
    // so a valid left high from the previous character is never captured.
    assign cap = armed && bus.blk_valid;
    // Capture has priority over an expiring timer in the same cycle.
    assign tmo = !cap && (tcnt == TW'(TIMEOUT));

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.blk_run   = blk_run_r;
    assign bus.blk_d     = blk_d_r;
    assign bus.q         = q_r;
    assign bus.err       = err_r;

    // Sequencer state, per-character run/wait bookkeeping and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            d_reg       <= '0;
            idx         <= '0;
            tcnt        <= '0;
            armed       <= 1'b0;
            out_valid_r <= 1'b0;
            blk_run_r   <= 1'b0;
            blk_d_r     <= '0;
            q_r         <= '0;
            err_r       <= 1'b0;
        end else begin
            blk_run_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        d_reg     <= bus.d;
                        q_r       <= '0;
                        err_r     <= 1'b0;
                        idx       <= '0;
                        blk_d_r   <= char_at(bus.d, 0);
                        blk_run_r <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    armed <= 1'b0;
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.blk_valid) begin
                        armed <= 1'b1;
                    end
                    if (cap || tmo) begin
                        // Timed-out characters leave an all-zero slice and flag the word
                        q_r[int'(idx)*SLICE_W +: SLICE_W] <= cap ? bus.blk_q : '0;
                        if (tmo) begin
                            err_r <= 1'b1;
                        end
                        if (last_char) begin
                            out_valid_r <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            idx       <= idx_nxt;
                            blk_d_r   <= char_at(d_reg, int'(idx_nxt));
                            blk_run_r <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end else begin
                        // Never passes TIMEOUT: reaching it always leaves WAIT
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emb_seq_ctrl.sv
// Self-checking bench: emulated emb_block, per-cycle transaction model and directed/random words.
// Latency: model predicts the exact cycle of every run pulse, capture and out_valid.
// Backpressure: out_ready forced low, high or randomised per phase.
module tb_emb_seq_ctrl;
    import emb_seq_ctrl_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    emb_seq_ctrl_if bus ();

    emb_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ord_mode;   // 0: out_ready low, 1: high, 2: random

    // Block behaviour for the word being presented
    logic [15:0] p_salt;
    int          p_k[N];
    bit          p_stale[N];
    bit          p_never[N];

    // Transaction model of the controller
    int          m_phase = 0;   // 0 idle, 1 busy, 2 result pending
    int          m_t = 0, m_ci = 0, m_ist = 0;
    bit          m_live = 1'b0;
    word_t       m_word;
    logic [15:0] m_salt;
    int          m_k[N];
    bit          m_stale[N];
    bit          m_never[N];
    qword_t      m_q = '0;
    logic        m_err = 1'b0;
    char_t       m_bd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_q(input string name, input qword_t act, input qword_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int s = 0; s < N; s++) begin
                if (act[s*SLICE_W +: SLICE_W] !== exp[s*SLICE_W +: SLICE_W]) begin
                    $display("FAIL %s slice %0d: got %h required %h", name, s,
                             act[s*SLICE_W +: SLICE_W], exp[s*SLICE_W +: SLICE_W]);
                    break;
                end
            end
        end
    endtask

    // Block valid at offset j from its run pulse (j=0 is the run cycle itself)
    function automatic bit vld(input int k, input bit st, input bit nv, input int j);
        return (st && j <= 1) || (!nv && j == k);
    endfunction

    // Wait offset at which a result is taken (needs a low sample first), 0 if never
    function automatic int capture_at(input int k, input bit st, input bit nv);
        bit low_seen = 1'b0;
        for (int j = 1; j <= TO + 1; j++) begin
            if (vld(k, st, nv, j) && low_seen) return j;
            if (!vld(k, st, nv, j)) low_seen = 1'b1;
        end
        return 0;
    endfunction

    // Last wait offset for a character: capture point, or timer expiry after TO+1 waits
    function automatic int last_wait(input int k, input bit st, input bit nv);
        int c = capture_at(k, st, nv);
        return (c > 0) ? c : TO + 1;
    endfunction

    function automatic emb_t emb_of(input char_t c, input logic [15:0] salt);
        emb_t r;
        for (int e = 0; e < EMB_DIM; e++) r[e*N_LEN +: N_LEN] = salt + 16'(c) + 16'(e) * 16'h0400;
        return r;
    endfunction

    function automatic emb_t noise();
        emb_t r;
        for (int i = 0; i < SLICE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_prof(input int k, input bit st);
        for (int c = 0; c < N; c++) begin
            p_k[c] = k; p_stale[c] = st; p_never[c] = 1'b0;
        end
    endtask

    // Model: compare this cycle's outputs, then step to the next cycle
    always @(negedge clk) begin : model
        int j;
        j = m_t - m_ist;
        if (m_live) begin
            check("in_ready", bus.in_ready, m_phase == 0);
            check("out_valid", bus.out_valid, m_phase == 2);
            check("blk_run", bus.blk_run, m_phase == 1 && j == 0);
            check("blk_d", bus.blk_d, m_bd);
            check("err", bus.err, m_err);
            check_q("q", bus.q, m_q);
        end
        if (rst) begin
            m_phase = 0; m_q = '0; m_err = 1'b0; m_bd = '0;
            m_t = 0; m_ci = 0; m_ist = 0; m_live = 1'b1;
        end else if (m_live) begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_word = bus.d; m_salt = p_salt;
                    m_k = p_k; m_stale = p_stale; m_never = p_never;
                    m_q = '0; m_err = 1'b0;
                    m_phase = 1; m_t = 1; m_ci = 0; m_ist = 1;
                    m_bd = char_at(bus.d, 0);
                end
                1: begin
                    if (j == last_wait(m_k[m_ci], m_stale[m_ci], m_never[m_ci])) begin
                        if (capture_at(m_k[m_ci], m_stale[m_ci], m_never[m_ci]) > 0)
                            m_q[m_ci*SLICE_W +: SLICE_W] = emb_of(char_at(m_word, m_ci), m_salt);
                        else
                            m_err = 1'b1;
                        if (m_ci == N - 1) begin
                            m_phase = 2;
                        end else begin
                            m_ci++;
                            m_ist = m_t + 1;
                            m_bd = char_at(m_word, m_ci);
                        end
                    end
                    m_t++;
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    // Emulated emb_block and result consumer, driven just after each rising edge
    initial begin : responder
        int jj;
        bit v;
        bus.blk_valid = 1'b0;
        bus.blk_q     = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            v = 1'b0;
            if (m_phase == 1) begin
                jj = m_t - m_ist;
                v = vld(m_k[m_ci], m_stale[m_ci], m_never[m_ci], jj);
            end
            bus.blk_valid = v;
            bus.blk_q     = v ? emb_of(char_at(m_word, m_ci), m_salt) : noise();
            case (ord_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic present(input word_t w, input logic [15:0] salt, output int acc);
        @(posedge clk); #1;
        bus.d = w; p_salt = salt; bus.in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept: in_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_out(output int seen);
        seen = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin seen = cyc; break; end
        end
        checks++;
        if (seen < 0) begin
            errors++;
            $display("FAIL out_valid wait: stayed 0, required 1");
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"}, bus.in_ready, 1);
        check({tag, " out_valid"}, bus.out_valid, 0);
        check({tag, " blk_run"}, bus.blk_run, 0);
        check({tag, " blk_d"}, bus.blk_d, 0);
        check({tag, " err"}, bus.err, 0);
        check_q({tag, " q"}, bus.q, '0);
    endtask

    initial begin : main
        int a, o, hs, cnt, exp_lat;
        word_t w;
        rst = 1'b1; bus.in_valid = 1'b0; bus.d = '0; ord_mode = 1; p_salt = '0;
        set_prof(3, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // Basic: chars 1..10, response three cycles after each run
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(c + 1);
        set_prof(3, 1'b0);
        present(w, 16'h0100, a);
        wait_out(o);
        check("basic latency", 64'(o - a), 41);
        check("basic q[0].e0", bus.q[0 +: 16], 16'h0101);
        check("basic q[9].e23", bus.q[9*SLICE_W + 23*N_LEN +: 16], 16'h5D0A);
        check("basic err", bus.err, 0);

        // Stale valid: block still high through run and first wait cycle
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(8'h40 + c);
        set_prof(4, 1'b1);
        present(w, 16'h0A00, a);
        wait_out(o);
        check("stale latency", 64'(o - a), 51);
        check("stale err", bus.err, 0);

        // Timeout on char 4
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(8'h21 + c);
        set_prof(3, 1'b0);
        p_never[4] = 1'b1;
        present(w, 16'h0200, a);
        wait_out(o);
        check("timeout latency", 64'(o - a), 47);
        check("timeout err", bus.err, 1);
        check("timeout slice4 zero", (bus.q[4*SLICE_W +: SLICE_W] == '0), 1);
        check("timeout q[5].e0", bus.q[5*SLICE_W +: 16], 16'h0226);

        // Backpressure: result held 20 cycles while another word waits
        ord_mode = 0;
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(8'h80 + 3 * c);
        set_prof(2, 1'b0);
        present(w, 16'h0300, a);
        wait_out(o);
        check("bp word A latency", 64'(o - a), 31);
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(8'hC0 + c);
        bus.d = w; p_salt = 16'h0400; set_prof(3, 1'b0); bus.in_valid = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            check("bp in_ready", bus.in_ready, 0);
            if (bus.blk_run === 1'b1) cnt++;
        end
        check("bp no blk_run", 64'(cnt), 0);
        ord_mode = 1;
        hs = -1; a = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hs < 0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs = cyc;
            if (bus.in_ready === 1'b1) begin a = cyc; break; end
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        check("bp accept after release", 64'(a - hs), 1);
        wait_out(o);
        check("bp word B latency", 64'(o - a), 41);

        // Reset during the wait of char 6, then a clean word
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(8'h10 + c);
        set_prof(3, 1'b0);
        present(w, 16'h0500, a);
        cnt = 0;
        for (int i = 0; i < 300 && cnt < 7; i++) begin
            @(negedge clk);
            if (bus.blk_run === 1'b1) cnt++;
        end
        check("runs before reset", 64'(cnt), 7);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        for (int c = 0; c < N; c++) w[c*CHAR_LEN +: CHAR_LEN] = 8'(8'h60 + c);
        set_prof(3, 1'b0);
        p_stale[0] = 1'b1; p_k[0] = 4;
        present(w, 16'h0600, a);
        wait_out(o);
        check("post-reset latency", 64'(o - a), 42);
        check("post-reset err", bus.err, 0);

        // Random words, random block timing, random consumer stalls
        ord_mode = 2;
        for (int wi = 0; wi < 12; wi++) begin
            exp_lat = 1;
            for (int c = 0; c < N; c++) begin
                w[c*CHAR_LEN +: CHAR_LEN] = 8'($urandom);
                p_k[c]     = $urandom_range(1, 6);
                p_stale[c] = ($urandom_range(0, 2) == 0);
                p_never[c] = ($urandom_range(0, 9) == 0);
                exp_lat += last_wait(p_k[c], p_stale[c], p_never[c]) + 1;
            end
            present(w, 16'($urandom), a);
            wait_out(o);
            check("random latency", 64'(o - a), 64'(exp_lat));
        end

        ord_mode = 1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
